// File: rtl/seven_segments_capture.sv
// rtl/seven_segments_capture.sv - recovers the two-digit BCD value from a multiplexed 7-segment bus
// Optional feature macro: CAPTURE_CHANGE_ONLY_EN (suppress valid_o for repeated identical pairs)
module seven_segments_capture #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 108000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] anodo_i,
    input  logic [6:0] catodo_i,
    output logic [7:0] bcd_o,
    output logic       valid_o,
    output logic       seg_err_o,
    output logic       lost_o
);
    localparam int RW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CYCLES);
    localparam logic [RW-1:0] RUN_ONE = RW'(1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_PRE = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {SEEK, HALF_U, HALF_T} state_t;

    state_t        state_q, state_d;
    logic [8:0]    sample_q, last_q;
    logic [RW-1:0] run_q, run_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [3:0]    held_q, held_d;
    logic [7:0]    bcd_d, pair;
    logic          valid_d, err_d, lost_d;
    logic          accept, pos_units, digit_ok, valid_acc, bad_acc, expire, complete;
    logic [3:0]    digit;
    logic          report_q, report_d;

    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'b1000000: decode = {1'b1, 4'd0};
            7'b1111001: decode = {1'b1, 4'd1};
            7'b0100100: decode = {1'b1, 4'd2};
            7'b0110000: decode = {1'b1, 4'd3};
            7'b0011001: decode = {1'b1, 4'd4};
            7'b0010010: decode = {1'b1, 4'd5};
            7'b0000010: decode = {1'b1, 4'd6};
            7'b1111000: decode = {1'b1, 4'd7};
            7'b0000000: decode = {1'b1, 4'd8};
            7'b0010000: decode = {1'b1, 4'd9};
            default:    decode = 5'b0_0000;
        endcase
    endfunction

    // Run length of the registered sample; accept fires on the single cycle it first hits the limit.
    always_comb begin
        pos_units = (sample_q[8:7] == 2'b10);
        if (sample_q[8:7] == 2'b11 || sample_q[8:7] == 2'b00) begin
            run_d = '0;
        end else if (sample_q != last_q) begin
            run_d = RUN_ONE;
        end else if (run_q == RUN_MAX) begin
            run_d = RUN_MAX;
        end else begin
            run_d = run_q + 1'b1;
        end
        accept            = (run_d == RUN_MAX) && (run_q != RUN_MAX);
        {digit_ok, digit} = decode(sample_q[6:0]);
        valid_acc         = accept && digit_ok;
        bad_acc           = accept && !digit_ok;
    end

    // A valid accept on the expiry cycle clears the counter first, so it suppresses the expiry.
    always_comb begin
        if (valid_acc) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_MAX) begin
            tmo_d = TMO_MAX;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
        expire = !valid_acc && (tmo_q == TMO_PRE);
    end

    always_comb begin
        state_d  = state_q;
        held_d   = held_q;
        bcd_d    = bcd_o;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        lost_d   = lost_o;
        report_d = report_q;
        complete = 1'b0;
        pair     = pos_units ? {held_q, digit} : {digit, held_q};
        if (expire) begin
            state_d  = SEEK;
            lost_d   = 1'b1;
            report_d = 1'b1;
        end
        if (bad_acc) begin
            err_d   = 1'b1;
            state_d = SEEK;
        end else if (valid_acc) begin
            lost_d = 1'b0;
            case (state_q)
                SEEK: begin
                    state_d = pos_units ? HALF_U : HALF_T;
                    held_d  = digit;
                end
                HALF_U: begin
                    if (pos_units) held_d = digit;
                    else complete = 1'b1;
                end
                HALF_T: begin
                    if (!pos_units) held_d = digit;
                    else complete = 1'b1;
                end
                default: state_d = SEEK;
            endcase
        end
        if (complete) begin
            state_d  = SEEK;
            bcd_d    = pair;
`ifdef CAPTURE_CHANGE_ONLY_EN
            valid_d  = report_q || (pair != bcd_o);
`else
            valid_d  = 1'b1;
`endif
            report_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sample_q  <= 9'h1FF;
            last_q    <= 9'h1FF;
            run_q     <= '0;
            tmo_q     <= '0;
            state_q   <= SEEK;
            held_q    <= 4'd0;
            bcd_o     <= 8'h00;
            valid_o   <= 1'b0;
            seg_err_o <= 1'b0;
            lost_o    <= 1'b0;
            report_q  <= 1'b1;
        end else begin
            sample_q  <= {anodo_i, catodo_i};
            last_q    <= sample_q;
            run_q     <= run_d;
            tmo_q     <= tmo_d;
            state_q   <= state_d;
            held_q    <= held_d;
            bcd_o     <= bcd_d;
            valid_o   <= valid_d;
            seg_err_o <= err_d;
            lost_o    <= lost_d;
            report_q  <= report_d;
        end
    end
endmodule

// File: tb/tb_seven_segments_capture.sv
// tb/tb_seven_segments_capture.sv - scoreboard bench for seven_segments_capture
// Slot-level reference model predicts each report/error event with its edge number.
module tb_seven_segments_capture;
    localparam int S = 16;
    localparam int T = 100;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [1:0] anodo_i = 2'b11;
    logic [6:0] catodo_i = 7'h7F;
    logic [7:0] bcd_o;
    logic       valid_o, seg_err_o, lost_o;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    seven_segments_capture #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .anodo_i(anodo_i), .catodo_i(catodo_i),
        .bcd_o(bcd_o), .valid_o(valid_o), .seg_err_o(seg_err_o), .lost_o(lost_o)
    );

    typedef struct {
        int         at_edge;
        bit         err;
        logic [7:0] bcd;
        bit         lost;
    } ev_t;
    ev_t exp_q[$];

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // model state: held position 0=none 1=units 2=tens
    int         held_pos = 0;
    int         held_dig = 0;
    logic [7:0] m_bcd = 8'h00;
    int         m_last = 0;
    bit         m_lost = 0;
    bit         m_first = 1;
    logic [8:0] prev_pat = 9'h1FF;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_accept(input int a, input bit units, input logic [6:0] ct);
        int d;
        int pos;
        bit report;
        logic [7:0] pr;
        d = -1;
        for (int i = 0; i < 10; i++) if (seg_tab[i] == ct) d = i;
        if (d < 0) begin
            if (m_last + T <= a) begin m_lost = 1; m_first = 1; end
            held_pos = 0;
            exp_q.push_back('{at_edge: a, err: 1'b1, bcd: m_bcd, lost: m_lost});
        end else begin
            if (m_last + T < a) begin held_pos = 0; m_first = 1; end
            m_lost = 0;
            m_last = a;
            pos = units ? 1 : 2;
            if (held_pos == 0 || held_pos == pos) begin
                held_pos = pos;
                held_dig = d;
            end else begin
                pr = units ? {held_dig[3:0], d[3:0]} : {d[3:0], held_dig[3:0]};
                report = 1;
`ifdef CAPTURE_CHANGE_ONLY_EN
                report = m_first || (pr != m_bcd);
`endif
                m_first = 0;
                m_bcd = pr;
                held_pos = 0;
                if (report) exp_q.push_back('{at_edge: a, err: 1'b0, bcd: pr, lost: 1'b0});
            end
        end
    endtask

    // Called just after a rising edge; the pattern is registered on the next len edges.
    task automatic drive_slot(input logic [1:0] an, input logic [6:0] ct, input int len);
        int n;
        n = cyc;
        anodo_i = an;
        catodo_i = ct;
        prev_pat = {an, ct};
        if ((an == 2'b10 || an == 2'b01) && len >= S) model_accept(n + 1 + S, an == 2'b10, ct);
        repeat (len) begin @(posedge clk_i); #1; end
    endtask

    task automatic do_reset();
        drive_slot(2'b11, 7'h7F, 3);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        held_pos = 0; m_bcd = 8'h00; m_lost = 0; m_first = 1; m_last = cyc;
        prev_pat = 9'h1FF;
    endtask

    always @(negedge clk_i) begin
        if (!rst_i && (valid_o || seg_err_o)) begin
            check("valid_err_exclusive", int'(valid_o && seg_err_o), 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: valid=%0d seg_err=%0d bcd=%02h at edge %0d, none expected",
                         valid_o, seg_err_o, bcd_o, cyc);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("evt_edge", cyc, e.at_edge);
                check("evt_is_err", seg_err_o, e.err);
                check("evt_bcd", bcd_o, e.bcd);
                check("evt_lost", lost_o, e.lost);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        m_last = cyc;
        check("rst_bcd", bcd_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_seg_err", seg_err_o, 0);
        check("rst_lost", lost_o, 0);

        drive_slot(2'b10, seg_tab[5], 20);
        drive_slot(2'b01, seg_tab[3], 20);
        check("pair_35", bcd_o, 8'h35);

        drive_slot(2'b10, seg_tab[5], 15);
        drive_slot(2'b11, 7'h7F, 5);

        drive_slot(2'b10, 7'h7F, 16);
        drive_slot(2'b01, seg_tab[3], 16);
        drive_slot(2'b10, seg_tab[7], 20);
        check("pair_37", bcd_o, 8'h37);

        drive_slot(2'b11, 7'h7F, 105);
        check("lost_after_idle", lost_o, 1);
        drive_slot(2'b10, seg_tab[1], 20);
        check("lost_cleared", lost_o, 0);
        drive_slot(2'b01, seg_tab[2], 20);
        check("pair_21", bcd_o, 8'h21);

        drive_slot(2'b10, seg_tab[4], 20);
        do_reset();
        check("rst2_bcd", bcd_o, 0);
        check("rst2_valid", valid_o, 0);
        check("rst2_lost", lost_o, 0);
        drive_slot(2'b01, seg_tab[9], 20);
        drive_slot(2'b10, seg_tab[0], 20);
        check("pair_90", bcd_o, 8'h90);

        for (int k = 0; k < 3; k++) begin
            drive_slot(2'b10, seg_tab[8], 18);
            drive_slot(2'b01, seg_tab[2], 18);
        end
        check("pair_28", bcd_o, 8'h28);

        for (int k = 0; k < 160; k++) begin
            int r;
            int len;
            logic [1:0] an;
            logic [6:0] ct;
            r = $urandom_range(0, 99);
            if (r < 55) begin
                an = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
                ct = seg_tab[$urandom_range(0, 9)];
                len = $urandom_range(S - 2, S + 12);
            end else if (r < 65) begin
                an = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
                ct = 7'($urandom);
                len = S + $urandom_range(0, 4);
            end else if (r < 80) begin
                an = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
                ct = seg_tab[$urandom_range(0, 9)];
                len = $urandom_range(1, S - 1);
            end else if (r < 95) begin
                an = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
                ct = 7'($urandom);
                len = $urandom_range(1, 6);
            end else begin
                an = 2'b11;
                ct = 7'h7F;
                len = $urandom_range(T - 10, T + 30);
            end
            if ({an, ct} == prev_pat) an = an ^ 2'b11;
            drive_slot(an, ct, len);
        end

        drive_slot(2'b11, 7'h7F, S + 4);
        check("queue_drained", exp_q.size(), 0);
        check("final_bcd", bcd_o, m_bcd);
        check("final_lost", lost_o, int'(m_lost || (m_last + T <= cyc)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
